// File: rtl/blink_sched.sv
`default_nettype none
// ============================================================================
// Module      : blink_sched
// Description : Multi-channel LED blink scheduler. Per-channel programmable
//               half-period, toggle budget and run control, driven through a
//               shared valid/ready command port. Optional macro
//               BLINK_SCHED_SYNC_START_EN re-phases running channels on START.
// Revision    : 1.0 - initial release
// ============================================================================
module blink_sched #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int TOG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_cmd,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [TOG_W-1:0]  cfg_toggles,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);
    localparam logic [1:0] c_CMD_START  = 2'b00;
    localparam logic [1:0] c_CMD_STOP   = 2'b01;
    localparam logic [1:0] c_CMD_PAUSE  = 2'b10;
    localparam logic [1:0] c_CMD_RESUME = 2'b11;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_PAUSED = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // Accepted command is held one cycle, then applied; this also blocks the
    // port for that cycle so commands are at least two cycles apart.
    logic             r_pend_vld;
    logic [2:0]       r_pend_ch;
    logic [1:0]       r_pend_cmd;
    logic [CNT_W-1:0] r_pend_period;
    logic [TOG_W-1:0] r_pend_tog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld    <= 1'b0;
            r_pend_ch     <= '0;
            r_pend_cmd    <= '0;
            r_pend_period <= '0;
            r_pend_tog    <= '0;
        end else if (r_pend_vld) begin
            r_pend_vld    <= 1'b0;
        end else if (cfg_valid) begin
            r_pend_vld    <= 1'b1;
            r_pend_ch     <= cfg_ch;
            r_pend_cmd    <= cfg_cmd;
            r_pend_period <= cfg_period;
            r_pend_tog    <= cfg_toggles;
        end
    end

    assign cfg_ready = ~r_pend_vld;

`ifdef BLINK_SCHED_SYNC_START_EN
    logic w_sync_start;
    assign w_sync_start = r_pend_vld && (r_pend_cmd == c_CMD_START) &&
                          (32'(r_pend_ch) < 32'(NUM_CH));
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       r_st;
        logic [1:0]       w_st_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_per;
        logic [CNT_W-1:0] w_per_nxt;
        logic [TOG_W-1:0] r_rem;
        logic [TOG_W-1:0] w_rem_nxt;
        logic             r_led;
        logic             w_led_nxt;
        logic             r_done;
        logic             w_fin;
        logic             w_busy;
        logic             w_hit;

        assign w_hit = r_pend_vld && (r_pend_ch == 3'(c));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_st   <= c_ST_IDLE;
                r_cnt  <= '0;
                r_per  <= '0;
                r_rem  <= '0;
                r_led  <= 1'b0;
                r_done <= 1'b0;
            end else begin
                r_st   <= w_st_nxt;
                r_cnt  <= w_cnt_nxt;
                r_per  <= w_per_nxt;
                r_rem  <= w_rem_nxt;
                r_led  <= w_led_nxt;
                r_done <= w_fin;
            end
        end

        // A command applied to this channel replaces counting for that cycle.
        always_comb begin
            w_st_nxt  = r_st;
            w_cnt_nxt = r_cnt;
            w_per_nxt = r_per;
            w_rem_nxt = r_rem;
            w_led_nxt = r_led;
            w_fin     = 1'b0;
            if (w_hit) begin
                case (r_pend_cmd)
                    c_CMD_START: begin
                        w_st_nxt  = c_ST_RUN;
                        w_per_nxt = r_pend_period;
                        w_rem_nxt = r_pend_tog;
                        w_cnt_nxt = '0;
                        w_led_nxt = 1'b0;
                    end
                    c_CMD_STOP: begin
                        w_st_nxt  = c_ST_IDLE;
                        w_cnt_nxt = '0;
                        w_led_nxt = 1'b0;
                    end
                    c_CMD_PAUSE: begin
                        if (r_st == c_ST_RUN) w_st_nxt = c_ST_PAUSED;
                    end
                    default: begin
                        if (r_st == c_ST_PAUSED) w_st_nxt = c_ST_RUN;
                    end
                endcase
            end
`ifdef BLINK_SCHED_SYNC_START_EN
            else if (w_sync_start && (r_st == c_ST_RUN)) begin
                w_cnt_nxt = '0;
                w_led_nxt = 1'b0;
            end
`endif
            else if (r_st == c_ST_RUN) begin
                if (r_cnt >= r_per) begin
                    w_led_nxt = ~r_led;
                    w_cnt_nxt = '0;
                    // A zero budget means free-run; it is never decremented.
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - TOG_W'(1);
                        if (r_rem == TOG_W'(1)) begin
                            w_st_nxt = c_ST_DONE;
                            w_fin    = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        always_comb begin
            w_busy = (r_st == c_ST_RUN) || (r_st == c_ST_PAUSED);
        end

        assign led[c]  = r_led;
        assign busy[c] = w_busy;
        assign done[c] = r_done;
    end

endmodule
`default_nettype wire
